// File: rtl/asu_pipe.sv
// asu_pipe: two-stage add/sub/shift unit with valid/ready handshakes on both sides.
// Optional saturating ADD/SUB when the macro ASU_SAT_EN is defined; default build wraps.
module asu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_SHL = 2'b10,
        OP_SHR = 2'b11
    } op_e;

    // Result packed as {carry, value}; shifts use a one-bit extension to catch the bit shifted out.
    function automatic logic [WIDTH:0] asu_calc(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH:0] ext;
        logic [WIDTH:0] res;
        logic [SHW-1:0] s;
        s   = b[SHW-1:0];
        ext = '0;
        res = '0;
        case (op_e'(op))
            OP_ADD: begin
                ext = {1'b0, a} + {1'b0, b};
                res = ext;
`ifdef ASU_SAT_EN
                if (ext[WIDTH]) begin
                    res[WIDTH-1:0] = '1;
                end else begin
                    res[WIDTH-1:0] = ext[WIDTH-1:0];
                end
`endif
            end
            OP_SUB: begin
                ext = {1'b0, a} - {1'b0, b};
                res = ext;
`ifdef ASU_SAT_EN
                if (ext[WIDTH]) begin
                    res[WIDTH-1:0] = '0;
                end else begin
                    res[WIDTH-1:0] = ext[WIDTH-1:0];
                end
`endif
            end
            OP_SHL: begin
                ext = {1'b0, a} << s;
                res = ext;
            end
            OP_SHR: begin
                ext = {a, 1'b0} >> s;
                res = {ext[0], ext[WIDTH:1]};
            end
            default: begin
                res = '0;
            end
        endcase
        return res;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH:0]   s1_data_q,  s1_data_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH:0]   s2_data_q,  s2_data_d;
    logic             s1_load;
    logic             s2_load;

    // Load enables: a stage advances when it is empty or its successor is moving.
    always_comb begin
        s2_load = !s2_valid_q || out_ready;
        s1_load = !s1_valid_q || s2_load;
    end

    assign in_ready = s1_load;

    // Next-state for both stages; data registers only capture valid beats.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = asu_calc(mode, x, y);
            end else begin
                s1_data_d = s1_data_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = s1_data_q;
            end else begin
                s2_data_d = s2_data_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers with synchronous active-low reset dropping any in-flight beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out       = s2_data_q[WIDTH-1:0];
    assign carry     = s2_data_q[WIDTH];

endmodule

// File: tb/tb_asu_pipe.sv
// tb_asu_pipe: scoreboard bench for asu_pipe with directed vectors and random streaming.
// Honours ASU_SAT_EN in its reference model when the macro is defined.
module tb_asu_pipe;

    localparam int W = 8;
`ifdef ASU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [1:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         carry;

    int total;
    int bad;
    logic [W:0] exp_q[$];

    asu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .carry(carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model from the arithmetic rules, returns {carry, value}.
    function automatic logic [W:0] ref_calc(input logic [1:0] m, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        int unsigned ua, ub, s, r, md;
        bit c;
        ua = a; ub = b; md = 1 << W; s = ub % W;
        case (m)
            2'd0: begin r = ua + ub; c = (r >= md); r = r % md; if (SAT && c) r = md - 1; end
            2'd1: begin c = (ua < ub); r = (ua + md - ub) % md; if (SAT && c) r = 0; end
            2'd2: begin r = ua * (1 << s); c = ((r / md) % 2) == 1; r = r % md; end
            default: begin r = ua / (1 << s); c = (s == 0) ? 1'b0 : (((ua / (1 << (s - 1))) % 2) == 1); end
        endcase
        return {c, r[W-1:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rand();
        in_valid = 1'b1;
        x = W'($urandom);
        y = W'($urandom);
        mode = 2'($urandom);
    endtask

    // Scoreboard producer: record the expected result of every accepted beat.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back(ref_calc(mode, x, y));
        end
    end

    // Scoreboard monitor: compare every consumed output beat in order.
    always @(negedge clk) begin
        logic [W:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got=%0h expected=none", out);
            end else begin
                e = exp_q.pop_front();
                chk("sb_out", 32'(out), 32'(e[W-1:0]));
                chk("sb_carry", 32'(carry), 32'(e[W]));
            end
        end
    end

    task automatic one_beat(input string nm, input logic [1:0] m, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] eo, input logic ec);
        in_valid = 1'b1; mode = m; x = a; y = b;
        tick();
        in_valid = 1'b0;
        chk({nm, "_lat1"}, 32'(out_valid), 32'd0);
        tick();
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_out"}, 32'(out), 32'(eo));
        chk({nm, "_carry"}, 32'(carry), 32'(ec));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() != 0 || out_valid) tick();
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [W:0] held;
        total = 0; bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; mode = 2'b00; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        one_beat("add_f0_20", 2'b00, 8'hF0, 8'h20, SAT ? 8'hFF : 8'h10, 1'b1);
        one_beat("sub_05_07", 2'b01, 8'h05, 8'h07, SAT ? 8'h00 : 8'hFE, 1'b1);
        one_beat("sub_07_05", 2'b01, 8'h07, 8'h05, 8'h02, 1'b0);
        one_beat("shl_81_01", 2'b10, 8'h81, 8'h01, 8'h02, 1'b1);
        one_beat("shl_81_08", 2'b10, 8'h81, 8'h08, 8'h81, 1'b0);
        one_beat("shr_03_01", 2'b11, 8'h03, 8'h01, 8'h01, 1'b1);
        one_beat("shr_80_0f", 2'b11, 8'h80, 8'h0F, 8'h01, 1'b0);
        tick();

        // Back-to-back stream at full throughput.
        for (int i = 0; i < 10; i++) begin
            set_rand();
            #1;
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        drain();

        // Backpressure: two beats fill the pipe, third waits.
        out_ready = 1'b0;
        set_rand();
        held = ref_calc(mode, x, y);
        tick();
        set_rand();
        tick();
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        set_rand();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_out", 32'(out), 32'(held[W-1:0]));
            chk("bp_hold_carry", 32'(carry), 32'(held[W]));
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        drain();

        // Reset with both stages full.
        out_ready = 1'b0;
        set_rand();
        tick();
        set_rand();
        tick();
        in_valid = 1'b0;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out", 32'(out), 32'd0);
        chk("midrst_carry", 32'(carry), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick();

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            set_rand();
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
